// File: rtl/issue_index_decoder.sv
// ============================================================================
// issue_index_decoder
// ----------------------------------------------------------------------------
// Binary-to-one-hot decoder for the issue stage. Binary slot indices arrive
// under a valid/ready handshake and leave as registered one-hot slot vectors.
// A two-entry skid buffer (OUT + SKD) decouples the handshake. A busy mask
// records slots that have been issued downstream and not yet released. An
// entry is flagged with err when its index is out of range, or when the index
// collides with a busy slot or with an entry still held in the pipeline.
//
// Optional feature (compile-time macro): ISSUE_DEC_BYPASS_EN
//   Defined   : from EMPTY, a valid index meeting a ready consumer (no flush)
//               is presented combinationally in the same cycle and fires
//               without occupying OUT.
//   Undefined : outputs are always registered (minimum 1-cycle latency).
//
// Ports
//   clk_i           in   clock, rising edge
//   rst_i           in   asynchronous active-high reset
//   index_valid_i   in   input index valid
//   index_i         in   binary slot index  [DECODER_WIDTH_LOG]
//   index_ready_o   out  decoder can accept an index (registered)
//   flush_i         in   drop all pipeline entries, refuse input this cycle
//   release_vec_i   in   slots being freed this cycle [DECODER_WIDTH]
//   onehot_valid_o  out  output entry valid
//   onehot_o        out  decoded one-hot vector [DECODER_WIDTH]
//   onehot_err_o    out  entry out-of-range or duplicate
//   onehot_ready_i  in   consumer accepts the output entry
//   busy_vec_o      out  issued-but-not-released slots [DECODER_WIDTH]
// ============================================================================
module issue_index_decoder #(
    parameter int DECODER_WIDTH     = 32,
    parameter int DECODER_WIDTH_LOG = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         index_valid_i,
    input  logic [DECODER_WIDTH_LOG-1:0] index_i,
    output logic                         index_ready_o,
    input  logic                         flush_i,
    input  logic [DECODER_WIDTH-1:0]     release_vec_i,
    output logic                         onehot_valid_o,
    output logic [DECODER_WIDTH-1:0]     onehot_o,
    output logic                         onehot_err_o,
    input  logic                         onehot_ready_i,
    output logic [DECODER_WIDTH-1:0]     busy_vec_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Slot count widened to 32 bits so the range check works for any index
    // width, including non-power-of-2 slot counts.
    localparam logic [31:0] WIDTH_U = 32'(DECODER_WIDTH);

    // Binary index to one-hot; indices at or beyond the slot count match no
    // bit and therefore decode to all-zero.
    function automatic logic [DECODER_WIDTH-1:0] decode_idx(
        input logic [DECODER_WIDTH_LOG-1:0] idx
    );
        logic [DECODER_WIDTH-1:0] vec;
        vec = '0;
        for (int i = 0; i < DECODER_WIDTH; i++) begin
            if (idx == DECODER_WIDTH_LOG'(i)) begin
                vec[i] = 1'b1;
            end else begin
                vec[i] = 1'b0;
            end
        end
        return vec;
    endfunction

    state_e                   state_q, state_d;
    logic [DECODER_WIDTH-1:0] out_oh_q,  out_oh_d;
    logic                     out_err_q, out_err_d;
    logic [DECODER_WIDTH-1:0] skd_oh_q,  skd_oh_d;
    logic                     skd_err_q, skd_err_d;
    logic [DECODER_WIDTH-1:0] busy_q,    busy_d;
    logic                     ready_q,   ready_d;

    logic [DECODER_WIDTH-1:0] dec_s;
    logic                     in_range_s;
    logic                     dup_s;
    logic                     new_err_s;
    logic                     out_valid_s;
    logic                     skd_valid_s;
    logic                     accept_s;
    logic                     fire_s;
    logic                     byp_s;
    logic [DECODER_WIDTH-1:0] held_vec_s;

    assign out_valid_s = (state_q != ST_EMPTY);
    assign skd_valid_s = (state_q == ST_TWO);

    assign dec_s      = decode_idx(index_i);
    assign in_range_s = ({{(32-DECODER_WIDTH_LOG){1'b0}}, index_i} < WIDTH_U);

    // Everything that already claims a slot: busy slots plus any entry still
    // in flight. The OUT entry counts even when it fires this cycle because
    // its busy bit only lands at the coming edge.
    assign held_vec_s = busy_q
                      | (out_valid_s ? out_oh_q : {DECODER_WIDTH{1'b0}})
                      | (skd_valid_s ? skd_oh_q : {DECODER_WIDTH{1'b0}});
    assign dup_s      = |(dec_s & held_vec_s);
    assign new_err_s  = ~in_range_s | dup_s;

`ifdef ISSUE_DEC_BYPASS_EN
    // Zero-latency path: only from EMPTY, so the duplicate check reduces to
    // the busy mask (OUT and SKD are both empty).
    assign byp_s = (state_q == ST_EMPTY) & index_valid_i & onehot_ready_i & ~flush_i;
`else
    assign byp_s = 1'b0;
`endif

    assign accept_s = index_valid_i & ready_q & ~flush_i;

    assign index_ready_o  = ready_q;
    assign onehot_valid_o = out_valid_s | byp_s;
    assign onehot_o       = byp_s ? dec_s : out_oh_q;
    assign onehot_err_o   = byp_s ? new_err_s : out_err_q;
    assign busy_vec_o     = busy_q;

    assign fire_s = onehot_valid_o & onehot_ready_i;

    // Next-state, skid-buffer data and busy-mask computation.
    always_comb begin
        state_d   = state_q;
        out_oh_d  = out_oh_q;
        out_err_d = out_err_q;
        skd_oh_d  = skd_oh_q;
        skd_err_d = skd_err_q;

        if (flush_i) begin
            state_d   = ST_EMPTY;
            out_oh_d  = '0;
            out_err_d = 1'b0;
            skd_oh_d  = '0;
            skd_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    // A bypassed entry fires straight through and never
                    // occupies OUT.
                    if (accept_s && !byp_s) begin
                        out_oh_d  = dec_s;
                        out_err_d = new_err_s;
                        state_d   = ST_ONE;
                    end else begin
                        state_d   = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && fire_s) begin
                        out_oh_d  = dec_s;
                        out_err_d = new_err_s;
                        state_d   = ST_ONE;
                    end else if (accept_s) begin
                        skd_oh_d  = dec_s;
                        skd_err_d = new_err_s;
                        state_d   = ST_TWO;
                    end else if (fire_s) begin
                        state_d   = ST_EMPTY;
                    end else begin
                        state_d   = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // ready is low in TWO, so no accept can coincide here.
                    if (fire_s) begin
                        out_oh_d  = skd_oh_q;
                        out_err_d = skd_err_q;
                        state_d   = ST_ONE;
                    end else begin
                        state_d   = ST_TWO;
                    end
                end
                default: begin
                    state_d   = ST_EMPTY;
                    out_oh_d  = '0;
                    out_err_d = 1'b0;
                    skd_oh_d  = '0;
                    skd_err_d = 1'b0;
                end
            endcase
        end

        // Release first, then OR in the issuing slot so a same-cycle issue
        // of a released slot keeps it busy. Error entries never mark busy.
        // Flush does not gate this: an entry firing in the flush cycle counts.
        if (fire_s && !onehot_err_o) begin
            busy_d = (busy_q & ~release_vec_i) | onehot_o;
        end else begin
            busy_d = busy_q & ~release_vec_i;
        end

        ready_d = (state_d != ST_TWO);
    end

    // Pipeline state, data and busy-mask registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_EMPTY;
            out_oh_q  <= '0;
            out_err_q <= 1'b0;
            skd_oh_q  <= '0;
            skd_err_q <= 1'b0;
            busy_q    <= '0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            out_oh_q  <= out_oh_d;
            out_err_q <= out_err_d;
            skd_oh_q  <= skd_oh_d;
            skd_err_q <= skd_err_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
        end
    end

endmodule

// File: tb/tb_issue_index_decoder.sv
module tb_issue_index_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // 32-slot instance
    logic        iv = 1'b0;
    logic [4:0]  idx = 5'd0;
    logic        rdy_o;
    logic        flush = 1'b0;
    logic [31:0] rel = 32'd0;
    logic        ov;
    logic [31:0] oh;
    logic        oerr;
    logic        rdy = 1'b0;
    logic [31:0] busy;

    // 20-slot instance (non-power-of-2 range check)
    logic        iv20 = 1'b0;
    logic [4:0]  idx20 = 5'd0;
    logic        rdy20_o;
    logic        flush20 = 1'b0;
    logic [19:0] rel20 = 20'd0;
    logic        ov20;
    logic [19:0] oh20;
    logic        oerr20;
    logic        rdy20 = 1'b1;
    logic [19:0] busy20;

    int total = 0;
    int bad   = 0;

    logic [32:0] sb[$];
    logic [32:0] sb20[$];

    always #5 clk = ~clk;

    issue_index_decoder #(.DECODER_WIDTH(32), .DECODER_WIDTH_LOG(5)) dut (
        .clk_i(clk), .rst_i(rst),
        .index_valid_i(iv), .index_i(idx), .index_ready_o(rdy_o),
        .flush_i(flush), .release_vec_i(rel),
        .onehot_valid_o(ov), .onehot_o(oh), .onehot_err_o(oerr),
        .onehot_ready_i(rdy), .busy_vec_o(busy)
    );

    issue_index_decoder #(.DECODER_WIDTH(20), .DECODER_WIDTH_LOG(5)) dut20 (
        .clk_i(clk), .rst_i(rst),
        .index_valid_i(iv20), .index_i(idx20), .index_ready_o(rdy20_o),
        .flush_i(flush20), .release_vec_i(rel20),
        .onehot_valid_o(ov20), .onehot_o(oh20), .onehot_err_o(oerr20),
        .onehot_ready_i(rdy20), .busy_vec_o(busy20)
    );

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: an entry presented with ready high fires at the next edge.
    always @(negedge clk) begin
        if (!rst && ov && rdy) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {oerr, oh}, 33'h1_ffff_ffff);
            end else begin
                chk("scoreboard", {oerr, oh}, sb.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov20 && rdy20) begin
            if (sb20.size() == 0) begin
                chk("unexpected_out20", {13'd0, oerr20, oh20}, 33'h1_ffff_ffff);
            end else begin
                chk("scoreboard20", {13'd0, oerr20, oh20}, sb20.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    // Offer an index until accepted (bounded); push the expected entry.
    task automatic send(input logic [4:0] i, input logic [31:0] eoh, input logic eerr);
        int n;
        logic acc;
        n = 0;
        acc = 1'b0;
        iv = 1'b1;
        idx = i;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = rdy_o;
            cyc();
            n++;
        end
        iv = 1'b0;
        if (acc) sb.push_back({eerr, eoh});
        else chk("accept_timeout", 33'd0, 33'd1);
    endtask

    task automatic send20(input logic [4:0] i, input logic [19:0] eoh, input logic eerr);
        int n;
        logic acc;
        n = 0;
        acc = 1'b0;
        iv20 = 1'b1;
        idx20 = i;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = rdy20_o;
            cyc();
            n++;
        end
        iv20 = 1'b0;
        if (acc) sb20.push_back({13'd0, eerr, eoh});
        else chk("accept_timeout20", 33'd0, 33'd1);
    endtask

    task automatic release_all();
        rel = 32'hffff_ffff;
        cyc();
        rel = 32'd0;
    endtask

    initial begin
        int n;
        // Reset state
        #12;
        @(negedge clk);
        chk("rst_valid", {32'd0, ov}, 33'd0);
        chk("rst_onehot", {1'b0, oh}, 33'd0);
        chk("rst_busy", {1'b0, busy}, 33'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {32'd0, rdy_o}, 33'd1);
        cyc();

        // Basic decode
        rdy = 1'b1;
        send(5'd5, 32'h0000_0020, 1'b0);
        idle(2);
        @(negedge clk);
        chk("busy_5", {1'b0, busy}, {1'b0, 32'h0000_0020});
        cyc();
        send(5'd0, 32'h0000_0001, 1'b0);
        send(5'd31, 32'h8000_0000, 1'b0);
        idle(2);
        @(negedge clk);
        chk("busy_0_31", {1'b0, busy}, {1'b0, 32'h8000_0021});
        cyc();
        release_all();
        @(negedge clk);
        chk("busy_released", {1'b0, busy}, 33'd0);
        cyc();

        // Backpressure and ordering
        rdy = 1'b0;
        send(5'd3, 32'h0000_0008, 1'b0);
        send(5'd7, 32'h0000_0080, 1'b0);
        @(negedge clk);
        chk("bp_ready_low", {32'd0, rdy_o}, 33'd0);
        chk("bp_hold_a", {1'b0, oh}, {1'b0, 32'h0000_0008});
        cyc();
        @(negedge clk);
        chk("bp_hold_b", {1'b0, oh}, {1'b0, 32'h0000_0008});
        cyc();
        rdy = 1'b1;
        @(negedge clk);
        chk("bp_first", {1'b0, oh}, {1'b0, 32'h0000_0008});
        cyc();
        @(negedge clk);
        chk("bp_second", {1'b0, oh}, {1'b0, 32'h0000_0080});
        chk("bp_ready_back", {32'd0, rdy_o}, 33'd1);
        cyc();
        @(negedge clk);
        chk("bp_drained", {32'd0, ov}, 33'd0);
        chk("bp_busy", {1'b0, busy}, {1'b0, 32'h0000_0088});
        cyc();
        release_all();

        // Duplicates: against busy, then against an entry held in OUT
        send(5'd9, 32'h0000_0200, 1'b0);
        idle(2);
        send(5'd9, 32'h0000_0200, 1'b1);
        idle(2);
        @(negedge clk);
        chk("dup_busy_kept", {1'b0, busy}, {1'b0, 32'h0000_0200});
        cyc();
        rel = 32'h0001_0000;
        cyc();
        rel = 32'd0;
        @(negedge clk);
        chk("release_nonbusy", {1'b0, busy}, {1'b0, 32'h0000_0200});
        cyc();
        rdy = 1'b0;
        send(5'd12, 32'h0000_1000, 1'b0);
        send(5'd12, 32'h0000_1000, 1'b1);
        rdy = 1'b1;
        idle(3);
        @(negedge clk);
        chk("dup_out_busy", {1'b0, busy}, {1'b0, 32'h0000_1200});
        cyc();
        release_all();

        // Release vs issue in the same cycle
        rdy = 1'b0;
        send(5'd4, 32'h0000_0010, 1'b0);
        rdy = 1'b1;
        rel = 32'h0000_0010;
        cyc();
        @(negedge clk);
        chk("issue_wins", {1'b0, busy}, {1'b0, 32'h0000_0010});
        cyc();
        rel = 32'd0;
        @(negedge clk);
        chk("release_only", {1'b0, busy}, 33'd0);
        cyc();

        // Flush from TWO with a valid input present
        send(5'd20, 32'h0010_0000, 1'b0);
        idle(2);
        rdy = 1'b0;
        send(5'd1, 32'h0000_0002, 1'b0);
        send(5'd2, 32'h0000_0004, 1'b0);
        @(negedge clk);
        chk("flush_pre_two", {32'd0, rdy_o}, 33'd0);
        cyc();
        iv = 1'b1;
        idx = 5'd6;
        flush = 1'b1;
        cyc();
        iv = 1'b0;
        flush = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_valid", {32'd0, ov}, 33'd0);
        chk("flush_ready", {32'd0, rdy_o}, 33'd1);
        chk("flush_busy", {1'b0, busy}, {1'b0, 32'h0010_0000});
        cyc();
        idle(1);
        @(negedge clk);
        chk("flush_not_taken", {32'd0, ov}, 33'd0);
        cyc();

        // An entry firing in the flush cycle still marks busy
        send(5'd7, 32'h0000_0080, 1'b0);
        rdy = 1'b1;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_fire_valid", {32'd0, ov}, 33'd0);
        chk("flush_fire_busy", {1'b0, busy}, {1'b0, 32'h0010_0080});
        cyc();

        // Out of range on the 20-slot instance
        send20(5'd25, 20'h00000, 1'b1);
        send20(5'd19, 20'h80000, 1'b0);
        idle(2);
        @(negedge clk);
        chk("busy20", {13'd0, busy20}, {13'd0, 20'h80000});
        cyc();

        // Asynchronous reset mid-cycle with an entry held and busy bits set
        rdy = 1'b0;
        send(5'd10, 32'h0000_0400, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("amid_valid", {32'd0, ov}, 33'd0);
        chk("amid_busy", {1'b0, busy}, 33'd0);
        chk("amid_busy20", {13'd0, busy20}, 33'd0);
        sb.delete();
        sb20.delete();
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {32'd0, rdy_o}, 33'd1);
        chk("post_rst_valid", {32'd0, ov}, 33'd0);
        cyc();

        // Everything expected must have been delivered
        n = 0;
        while ((sb.size() != 0 || sb20.size() != 0) && n < 20) begin
            cyc();
            n++;
        end
        chk("sb_empty", 33'(sb.size()), 33'd0);
        chk("sb20_empty", 33'(sb20.size()), 33'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
